// File: rtl/step_detector_adaptive.sv
// step_detector_adaptive
//   Detects steps in a stream of unsigned acceleration magnitudes. A peak
//   starts when a sample reaches the high threshold. It stays open while
//   samples remain at or above the low threshold. When it closes, its length
//   is judged. An accepted peak emits a step and starts a cooldown window;
//   peaks that are too short or too long are rejected with a reason code.
//   Optionally the high/low thresholds track an exponential moving average
//   of accepted peak amplitudes.
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   sample_valid   one-cycle strobe qualifying sample_mag
//   sample_mag     unsigned magnitude sample (DATA_W)
//   clear_count    synchronous clear of step statistics
//   step_pulse     one-cycle pulse per accepted step
//   step_count     saturating number of accepted steps
//   peak_amp       maximum magnitude of the last accepted peak
//   step_interval  samples between the last two accepted steps
//   interval_valid step_interval refers to a real previous step
//   reject_pulse   one-cycle pulse per rejected peak
//   reject_code    reason of the last reject (01 short, 10 long)
//   in_peak        high while a peak is being tracked
//   th_high_eff    effective peak-start threshold
module step_detector_adaptive #(
  parameter int DATA_W           = 16,
  parameter int CNT_W            = 16,
  parameter int TH_HIGH_MIN      = 250,
  parameter int TH_LOW           = 150,
  parameter int MIN_PEAK_SAMPLES = 8,
  parameter int MAX_PEAK_SAMPLES = 200,
  parameter int MIN_GAP_SAMPLES  = 200,
  parameter int MIN_GAP_CYCLES   = 50_000_000,
  parameter int ADAPT_EN         = 0,
  parameter int ADAPT_SHIFT      = 3,
  parameter int AVG_INIT         = 500
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_mag,
  input  logic              clear_count,
  output logic              step_pulse,
  output logic [CNT_W-1:0]  step_count,
  output logic [DATA_W-1:0] peak_amp,
  output logic [CNT_W-1:0]  step_interval,
  output logic              interval_valid,
  output logic              reject_pulse,
  output logic [1:0]        reject_code,
  output logic              in_peak,
  output logic [DATA_W-1:0] th_high_eff
);

  localparam int LEN_W = $clog2(MAX_PEAK_SAMPLES + 1);
  localparam logic [LEN_W-1:0]  MIN_LEN   = LEN_W'(MIN_PEAK_SAMPLES);
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_PEAK_SAMPLES);
  localparam logic [CNT_W-1:0]  GAP_SMP   = CNT_W'(MIN_GAP_SAMPLES);
  localparam logic [31:0]       GAP_CYC   = 32'(MIN_GAP_CYCLES);
  localparam logic [DATA_W-1:0] TH_HI_MIN = DATA_W'(TH_HIGH_MIN);
  localparam logic [DATA_W-1:0] TH_LO_FIX = DATA_W'(TH_LOW);

  typedef enum logic [1:0] {S_IDLE, S_PEAK, S_EVAL, S_COOLDOWN} state_t;

  state_t             r_state, w_state_next;
  logic [LEN_W-1:0]   r_peak_len;
  logic [DATA_W-1:0]  r_peak_max;
  logic [CNT_W-1:0]   r_gap_samples;
  logic [31:0]        r_gap_cycles;
  logic [DATA_W-1:0]  r_avg;
  logic               r_had_step;

  logic               w_start, w_extend, w_rej_long, w_rej_short, w_accept;
  logic               w_cool_done;
  logic [DATA_W-1:0]  w_avg_half, w_th_high, w_th_low, w_avg_next;
  logic signed [DATA_W:0] w_diff, w_adj;

  // Effective thresholds: fixed, or derived from the running peak average
  // with the floor TH_HIGH_MIN and the low threshold at 3/4 of the high one.
  assign w_avg_half  = r_avg >> 1;
  assign w_th_high   = (ADAPT_EN != 0) ? ((w_avg_half > TH_HI_MIN) ? w_avg_half : TH_HI_MIN)
                                       : TH_HI_MIN;
  assign w_th_low    = (ADAPT_EN != 0) ? (w_th_high - (w_th_high >> 2)) : TH_LO_FIX;
  assign th_high_eff = w_th_high;

  // EMA update done in one extra bit signed so a falling average works.
  assign w_diff     = $signed({1'b0, r_peak_max}) - $signed({1'b0, r_avg});
  assign w_adj      = w_diff >>> ADAPT_SHIFT;
  assign w_avg_next = DATA_W'($signed({1'b0, r_avg}) + w_adj);

  assign w_cool_done = (r_gap_samples >= GAP_SMP) && (r_gap_cycles >= GAP_CYC);
  assign in_peak     = (r_state == S_PEAK);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state decode plus the one-cycle control strobes for the datapath.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_extend     = 1'b0;
    w_rej_long   = 1'b0;
    w_rej_short  = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sample_valid && (sample_mag >= w_th_high)) begin
          w_start      = 1'b1;
          w_state_next = S_PEAK;
        end
      end
      S_PEAK: begin
        if (sample_valid) begin
          if (sample_mag >= w_th_low) begin
            if (r_peak_len < MAX_LEN) begin
              w_extend = 1'b1;
            end else begin
              w_rej_long   = 1'b1;
              w_state_next = S_IDLE;
            end
          end else begin
            w_state_next = S_EVAL;
          end
        end
      end
      S_EVAL: begin
        if ((r_peak_len >= MIN_LEN) && (r_peak_len <= MAX_LEN)) begin
          w_accept     = 1'b1;
          w_state_next = S_COOLDOWN;
        end else begin
          w_rej_short  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_COOLDOWN: begin
        if (w_cool_done) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Peak tracking: length and maximum of the open peak; length is dropped
  // whenever no peak is open.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_peak_len <= '0;
      r_peak_max <= '0;
    end else if (w_start) begin
      r_peak_len <= LEN_W'(1);
      r_peak_max <= sample_mag;
    end else if (w_extend) begin
      r_peak_len <= r_peak_len + LEN_W'(1);
      if (sample_mag > r_peak_max) r_peak_max <= sample_mag;
    end else if (w_rej_long || (r_state != S_PEAK)) begin
      r_peak_len <= '0;
    end
  end

  // Gap counters measure the distance since the last accepted step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gap_samples <= '0;
      r_gap_cycles  <= '0;
    end else if (w_accept) begin
      r_gap_samples <= '0;
      r_gap_cycles  <= '0;
    end else begin
      if (sample_valid && (r_gap_samples != '1)) r_gap_samples <= r_gap_samples + CNT_W'(1);
      if (r_gap_cycles != '1) r_gap_cycles <= r_gap_cycles + 32'd1;
    end
  end

  // Step statistics, pulses and reject reporting. A clear coinciding with an
  // accept still counts that step, as the first one after the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_pulse     <= 1'b0;
      step_count     <= '0;
      peak_amp       <= '0;
      step_interval  <= '0;
      interval_valid <= 1'b0;
      r_had_step     <= 1'b0;
      reject_pulse   <= 1'b0;
      reject_code    <= 2'b00;
      r_avg          <= DATA_W'(AVG_INIT);
    end else begin
      step_pulse   <= w_accept;
      reject_pulse <= w_rej_short || w_rej_long;
      if (w_rej_short) reject_code <= 2'b01;
      if (w_rej_long)  reject_code <= 2'b10;
      if (w_accept) begin
        if (clear_count)            step_count <= CNT_W'(1);
        else if (step_count != '1)  step_count <= step_count + CNT_W'(1);
        peak_amp       <= r_peak_max;
        step_interval  <= r_gap_samples;
        interval_valid <= r_had_step && !clear_count;
        r_had_step     <= 1'b1;
        if (ADAPT_EN != 0) r_avg <= w_avg_next;
      end else if (clear_count) begin
        step_count     <= '0;
        interval_valid <= 1'b0;
        r_had_step     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_step_detector_adaptive.sv
// tb_step_detector_adaptive
//   Self-checking bench for step_detector_adaptive. A fixed-threshold
//   instance is driven with directed and randomized sample streams (one sample
//   every 4 cycles) and compared every cycle against a sample-level model of
//   the step rules. A second, adaptive instance checks threshold tracking.
module tb_step_detector_adaptive;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_mag = '0;
  logic        clear_count = 1'b0;
  logic        step_pulse, interval_valid, reject_pulse, in_peak;
  logic [15:0] step_count, peak_amp, step_interval, th_high_eff;
  logic [1:0]  reject_code;

  logic        aValid = 1'b0;
  logic [15:0] aMag = '0;
  logic        aStep, aIv, aRej, aInPeak;
  logic [15:0] aCount, aAmp, aInterval, aThHigh;
  logic [1:0]  aCode;

  int testsRun = 0;
  int testsFailed = 0;
  int t = 0;
  bit randomClears = 1'b0;

  // Model state: peak progress, cooldown window and expected outputs.
  bit mInPeak, mPending, mCooling, mHad;
  int mLen, mMax, mGapS, mAccEdge;
  int expStep, expRej, expCode, expCount, expAmp, expInterval, expIv;

  always #5 clk = ~clk;

  step_detector_adaptive #(
    .DATA_W(16), .CNT_W(16), .TH_HIGH_MIN(250), .TH_LOW(150),
    .MIN_PEAK_SAMPLES(8), .MAX_PEAK_SAMPLES(200),
    .MIN_GAP_SAMPLES(20), .MIN_GAP_CYCLES(100),
    .ADAPT_EN(0), .ADAPT_SHIFT(3), .AVG_INIT(500)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
    .sample_mag(sample_mag), .clear_count(clear_count),
    .step_pulse(step_pulse), .step_count(step_count), .peak_amp(peak_amp),
    .step_interval(step_interval), .interval_valid(interval_valid),
    .reject_pulse(reject_pulse), .reject_code(reject_code),
    .in_peak(in_peak), .th_high_eff(th_high_eff)
  );

  step_detector_adaptive #(
    .DATA_W(16), .CNT_W(16), .TH_HIGH_MIN(250), .TH_LOW(150),
    .MIN_PEAK_SAMPLES(8), .MAX_PEAK_SAMPLES(200),
    .MIN_GAP_SAMPLES(20), .MIN_GAP_CYCLES(100),
    .ADAPT_EN(1), .ADAPT_SHIFT(3), .AVG_INIT(500)
  ) dutAdapt (
    .clk(clk), .reset_n(reset_n), .sample_valid(aValid),
    .sample_mag(aMag), .clear_count(1'b0),
    .step_pulse(aStep), .step_count(aCount), .peak_amp(aAmp),
    .step_interval(aInterval), .interval_valid(aIv),
    .reject_pulse(aRej), .reject_code(aCode),
    .in_peak(aInPeak), .th_high_eff(aThHigh)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int unsigned act, input int unsigned exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, t);
    end
  endtask

  // Return the model to its post-reset condition.
  task automatic modelReset();
    mInPeak = 0; mPending = 0; mCooling = 0; mHad = 0;
    mLen = 0; mMax = 0; mGapS = 0; mAccEdge = 0;
    expStep = 0; expRej = 0; expCode = 0; expCount = 0;
    expAmp = 0; expInterval = 0; expIv = 0;
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic modelEdge(input bit v, input int mag, input bit clr);
    bit acc;
    int gsPre;
    acc = 0;
    gsPre = mGapS;
    expStep = 0;
    expRej = 0;
    if (mPending) begin
      mPending = 0;
      if (mLen >= 8 && mLen <= 200) acc = 1;
      else begin expRej = 1; expCode = 1; end
      mLen = 0;
    end else if (mCooling) begin
      if (gsPre >= 20 && (t - mAccEdge - 1) >= 100) mCooling = 0;
    end else if (!mInPeak) begin
      if (v && mag >= 250) begin mInPeak = 1; mLen = 1; mMax = mag; end
    end else if (v) begin
      if (mag >= 150) begin
        if (mLen < 200) begin
          mLen++;
          if (mag > mMax) mMax = mag;
        end else begin
          expRej = 1; expCode = 2; mInPeak = 0; mLen = 0;
        end
      end else begin
        mInPeak = 0; mPending = 1;
      end
    end
    if (acc) mGapS = 0;
    else if (v && mGapS < 65535) mGapS++;
    if (acc) begin
      expStep = 1;
      expAmp = mMax;
      expInterval = gsPre;
      expIv = clr ? 0 : int'(mHad);
      expCount = clr ? 1 : ((expCount < 65535) ? expCount + 1 : expCount);
      mHad = 1;
      mCooling = 1;
      mAccEdge = t;
    end else if (clr) begin
      expCount = 0; expIv = 0; mHad = 0;
    end
  endtask

  task automatic compareAll();
    checkOutput("step_pulse", step_pulse, expStep);
    checkOutput("reject_pulse", reject_pulse, expRej);
    checkOutput("reject_code", reject_code, expCode);
    checkOutput("in_peak", in_peak, mInPeak);
    checkOutput("step_count", step_count, expCount);
    checkOutput("peak_amp", peak_amp, expAmp);
    checkOutput("step_interval", step_interval, expInterval);
    checkOutput("interval_valid", interval_valid, expIv);
  endtask

  // One clock cycle: drive inputs, take the edge, advance the model, compare.
  task automatic applyStimulus(input bit v, input int mag, input bit clr);
    sample_valid = v;
    sample_mag   = 16'(mag);
    clear_count  = clr;
    @(posedge clk);
    t++;
    modelEdge(v, mag, clr);
    #1;
    compareAll();
  endtask

  function automatic bit pickClr();
    return randomClears && ($urandom_range(0, 59) == 0);
  endfunction

  // One sample followed by three idle cycles; clrNext asserts clear_count
  // on the cycle right after the sample, where an accept would land.
  task automatic feedSample(input int mag, input bit clrNext);
    applyStimulus(1, mag, pickClr());
    applyStimulus(0, 0, clrNext | pickClr());
    applyStimulus(0, 0, pickClr());
    applyStimulus(0, 0, pickClr());
  endtask

  task automatic feedRun(input int n, input int mag);
    for (int i = 0; i < n; i++) feedSample(mag, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic applyReset();
    #2;
    reset_n = 1'b0;
    sample_valid = 1'b0;
    clear_count = 1'b0;
    modelReset();
    #1;
    compareAll();
    checkOutput("rst_th_high", th_high_eff, 250);
    repeat (2) begin @(posedge clk); t++; end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int n, len, lvl;
    modelReset();
    applyReset();

    // Adaptive instance: one 900 peak moves avg 500 -> 550, th 250 -> 275,
    // low threshold 188 -> 207.
    checkOutput("adapt_th_init", aThHigh, 250);
    for (int i = 0; i < 11; i++) begin
      aValid = 1'b1;
      aMag = (i < 10) ? 16'd900 : 16'd100;
      applyStimulus(0, 0, 0);
      aValid = 1'b0;
      repeat (3) applyStimulus(0, 0, 0);
    end
    checkOutput("adapt_count", aCount, 1);
    checkOutput("adapt_amp", aAmp, 900);
    checkOutput("adapt_th_high", aThHigh, 275);
    for (int i = 0; i < 29; i++) begin
      aValid = 1'b1;
      aMag = (i < 26) ? 16'd0 : ((i == 26) ? 16'd280 : ((i == 27) ? 16'd210 : 16'd200));
      applyStimulus(0, 0, 0);
      aValid = 1'b0;
      if (i == 26) checkOutput("adapt_start_280", aInPeak, 1);
      if (i == 27) checkOutput("adapt_hold_210", aInPeak, 1);
      if (i == 28) checkOutput("adapt_end_200", aInPeak, 0);
      repeat (3) applyStimulus(0, 0, 0);
    end

    // Basic accept, short reject, long reject.
    feedRun(10, 300); feedRun(1, 100); feedRun(30, 0);
    feedRun(5, 300);  feedRun(1, 100); feedRun(5, 0);
    feedRun(201, 300); feedRun(5, 0);
    // Length boundaries: 7 rejected, 8 and 200 accepted.
    feedRun(7, 300);   feedRun(1, 0); feedRun(5, 0);
    feedRun(8, 300);   feedRun(1, 0); feedRun(30, 0);
    feedRun(200, 300); feedRun(1, 0); feedRun(30, 0);
    // Peak during cooldown ignored, later peak gives a valid interval.
    feedRun(10, 300); feedRun(1, 100); feedRun(5, 0);
    feedRun(10, 300); feedRun(1, 0);   feedRun(24, 0);
    feedRun(10, 320); feedRun(1, 100); feedRun(30, 0);
    // Clear in the accept cycle, then reset in the middle of a peak.
    feedRun(10, 300); feedSample(100, 1'b1); feedRun(30, 0);
    feedRun(5, 300);
    applyReset();
    feedRun(3, 0);

    // Randomized bursts with random clears.
    randomClears = 1'b1;
    n = 0;
    while (n < 400) begin
      len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(195, 205))
                                         : int'($urandom_range(1, 14));
      for (int i = 0; i < len; i++) begin
        lvl = ($urandom_range(0, 5) == 0 && i > 0) ? int'($urandom_range(150, 249))
                                                   : int'($urandom_range(250, 1000));
        feedSample(lvl, 1'b0);
      end
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) feedSample(int'($urandom_range(0, 149)), 1'b0);
      n++;
    end
    randomClears = 1'b0;
    feedRun(30, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/step_detector_adaptive.md
STEP_DETECTOR_ADAPTIVE -- requirements
Module: step_detector_adaptive

Interface
REQ-001 SHALL have parameter DATA_W, default 16, magnitude sample width.
REQ-002 SHALL have parameter CNT_W, default 16, step_count and interval width.
REQ-003 SHALL have parameter TH_HIGH_MIN, default 250, peak-start threshold floor.
REQ-004 SHALL have parameter TH_LOW, default 150, peak-end threshold when ADAPT_EN=0.
REQ-005 SHALL have parameters MIN_PEAK_SAMPLES and MAX_PEAK_SAMPLES, defaults 8 and 200, inclusive valid peak length.
REQ-006 SHALL have parameters MIN_GAP_SAMPLES and MIN_GAP_CYCLES, defaults 200 and 50_000_000, cooldown length.
REQ-007 SHALL have parameters ADAPT_EN, ADAPT_SHIFT and AVG_INIT, defaults 0, 3 and 500: adaptive-threshold enable, EMA shift and EMA reset value.
REQ-008 SHALL have port clk, input, 1 bit: single clock; one clock, all logic on rising edge.
REQ-009 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port sample_valid, input, 1 bit: one-cycle strobe for a new sample.
REQ-011 SHALL have port sample_mag, input, DATA_W bits: unsigned dynamic magnitude, qualified by sample_valid.
REQ-012 SHALL have port clear_count, input, 1 bit: synchronous clear of step statistics.
REQ-013 SHALL have output step_pulse (1), step_count (CNT_W), peak_amp (DATA_W), step_interval (CNT_W), interval_valid (1).
REQ-014 SHALL have output reject_pulse (1), reject_code (2: 01 short, 10 long), in_peak (1), th_high_eff (DATA_W).

Function
REQ-015 SHALL implement states IDLE, PEAK, EVAL and COOLDOWN.
REQ-016 IDLE: on sample_valid with sample_mag >= th_high_eff, SHALL go to PEAK with peak_len=1 and peak_max=sample_mag.
REQ-017 PEAK, sample_valid with sample_mag >= th_low_eff and peak_len < MAX_PEAK_SAMPLES: SHALL increment peak_len and set peak_max=max(peak_max, sample_mag).
REQ-018 PEAK, same condition with peak_len == MAX_PEAK_SAMPLES: SHALL pulse reject_pulse with reject_code=10, clear peak_len, go to IDLE.
REQ-019 PEAK, sample_valid with sample_mag < th_low_eff: SHALL go to EVAL; the sample is not counted.
REQ-020 EVAL lasts exactly one cycle, ignores sample_valid for peak tracking, and SHALL accept when MIN_PEAK_SAMPLES <= peak_len <= MAX_PEAK_SAMPLES.
REQ-021 On accept, SHALL in the same registered update:
  - pulse step_pulse for 1 cycle;
  - saturating-increment step_count;
  - set peak_amp=peak_max;
  - set step_interval=gap_samples;
  - set interval_valid=1 unless this is the first step since reset/clear;
  - zero gap_samples and gap_cycles;
  - go to COOLDOWN.
REQ-022 On EVAL reject, SHALL pulse reject_pulse with reject_code=01 and go to IDLE; reject_code holds until the next reject.
REQ-023 COOLDOWN SHALL go to IDLE when gap_samples >= MIN_GAP_SAMPLES and gap_cycles >= MIN_GAP_CYCLES; a sample above threshold in COOLDOWN is ignored.
REQ-024 gap_samples (CNT_W) SHALL increment on sample_valid; gap_cycles (32 bit) SHALL increment every cycle; both saturate at all-ones; accept-clear overrides increment.
REQ-025 peak_len SHALL be cleared in IDLE and COOLDOWN.
REQ-026 in_peak SHALL equal (state == PEAK), decoded from the state register.
REQ-027 ADAPT_EN=0: th_high_eff SHALL equal TH_HIGH_MIN and th_low_eff SHALL equal TH_LOW.
REQ-028 ADAPT_EN=1: on each accept, avg SHALL become avg + ((peak_max - avg) arithmetic-shifted right by ADAPT_SHIFT), computed at DATA_W+1 signed.
REQ-029 ADAPT_EN=1: th_high_eff SHALL be max(TH_HIGH_MIN, avg>>1) and th_low_eff SHALL be th_high_eff - (th_high_eff>>2).
REQ-030 clear_count SHALL zero step_count, interval_valid and the first-step flag without altering state, gap counters or avg.
REQ-031 When clear_count coincides with accept, step_count SHALL become 1, interval_valid 0, and step_pulse SHALL still fire.

Reset
REQ-032 On reset_n=0, SHALL asynchronously set:
  - state=IDLE;
  - all pulses, step_count, peak_amp, step_interval, interval_valid, reject_code, peak_len, gap counters=0;
  - avg=AVG_INIT.
REQ-033 Reset mid-peak SHALL discard the peak with no step or reject pulse.

Verification
(Bench parameters: ADAPT_EN=0, TH 250/150, MIN/MAX 8/200, MIN_GAP_SAMPLES=20, MIN_GAP_CYCLES=100, samples every 4 cycles.)
REQ-034 10 samples of 300, then 100 -> one step_pulse, step_count=1, peak_amp=300, interval_valid=0, in_peak high for the 10-sample span.
REQ-035 5 samples of 300, then 100 -> reject_pulse, reject_code=01, step_count unchanged.
REQ-036 Continuous 300 -> reject_code=10 after peak_len reaches 200, back to IDLE, no step.
REQ-037 Second valid peak starting 5 samples after an accept -> ignored; a peak after 40 samples -> step_count=2, step_interval=gap_samples at accept, interval_valid=1.
REQ-038 ADAPT_EN=1, AVG_INIT=500, ADAPT_SHIFT=3, accepted peak_max=900 -> avg=550, th_high_eff=275, th_low_eff=207.
REQ-039 clear_count in the accept cycle -> step_count=1; reset_n low mid-peak -> all outputs 0, state IDLE.
